// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device transmitter.
// Sends one command byte (start, 8 data bits LSB first, odd parity, stop)
// to the keyboard over the open-drain PS/2 lines and checks the device ack.
// Pads: ps2_key_clk = clk_oe ? 0 : 'z; ps2_key_data = data_oe ? 0 : 'z.
module ps2_host_tx #(
  parameter int CLK_FREQ   = 36_000_000,
  parameter int INHIBIT_US = 100,
  parameter int TIMEOUT_US = 15000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       clk_oe,
  output logic       data_oe,
  output logic       busy,
  output logic       rx_inhibit,
  output logic       done,
  output logic       ack_err,
  output logic       timeout_err
);

  localparam logic [63:0] INHIBIT_CYC = 64'(CLK_FREQ) * 64'(INHIBIT_US) / 64'd1_000_000;
  localparam logic [63:0] TIMEOUT_CYC = 64'(CLK_FREQ) * 64'(TIMEOUT_US) / 64'd1_000_000;
  localparam logic [63:0] TIMER_MAX   = 64'd1_048_575;

  // The timer counts down to zero, so a load of N-1 gives N cycles.
  localparam logic [19:0] INHIBIT_LOAD = 20'(INHIBIT_CYC - 64'd1);
  localparam logic [19:0] TIMEOUT_LOAD = 20'(TIMEOUT_CYC - 64'd1);

  generate
    if (INHIBIT_CYC < 64'd1 || INHIBIT_CYC > TIMER_MAX ||
        TIMEOUT_CYC < 64'd1 || TIMEOUT_CYC > TIMER_MAX) begin : g_bad_timing
      $error("ps2_host_tx: derived cycle count does not fit the 20-bit timer");
    end
  endgenerate

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_INHIBIT   = 3'd1;
  localparam logic [2:0] ST_REQ       = 3'd2;
  localparam logic [2:0] ST_DATA      = 3'd3;
  localparam logic [2:0] ST_ACK       = 3'd4;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd5;

  logic [2:0]  state;
  logic [19:0] timer;
  logic [9:0]  sh;
  logic [3:0]  bitcnt;

  logic clk_meta, clk_sync, clk_prev;
  logic data_meta, data_sync;
  logic fall;

  // Two-flop synchronisers on both pads plus a delayed copy of the clock for edge detection;
  // reset to the idle-high line level so no false edge appears after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      clk_prev  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      clk_meta  <= ps2_clk_in;
      clk_sync  <= clk_meta;
      clk_prev  <= clk_sync;
      data_meta <= ps2_data_in;
      data_sync <= data_meta;
    end
  end

  assign fall = clk_prev & ~clk_sync;

  // busy stays high through the done cycle so a tx_start coinciding with done is ignored.
  assign busy       = (state != ST_IDLE) | done;
  assign rx_inhibit = busy;

  // Frame sequencer: inhibit, request-to-send, clock out 10 bits on device falls, ack, wait for idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      timer       <= '0;
      sh          <= '0;
      bitcnt      <= '0;
      clk_oe      <= 1'b0;
      data_oe     <= 1'b0;
      done        <= 1'b0;
      ack_err     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          clk_oe  <= 1'b0;
          data_oe <= 1'b0;
          if (tx_start && !done) begin
            sh          <= {1'b1, ~^tx_data, tx_data};
            ack_err     <= 1'b0;
            timeout_err <= 1'b0;
            timer       <= INHIBIT_LOAD;
            clk_oe      <= 1'b1;
            state       <= ST_INHIBIT;
          end
        end

        ST_INHIBIT: begin
          clk_oe <= 1'b1;
          if (timer == '0) begin
            data_oe <= 1'b1;
            timer   <= TIMEOUT_LOAD;
            state   <= ST_REQ;
          end else begin
            timer <= timer - 20'd1;
          end
        end

        ST_REQ: begin
          clk_oe <= 1'b0;
          if (fall) begin
            data_oe <= ~sh[0];
            sh      <= {1'b1, sh[9:1]};
            bitcnt  <= 4'd1;
            timer   <= TIMEOUT_LOAD;
            state   <= ST_DATA;
          end else if (timer == '0) begin
            clk_oe      <= 1'b0;
            data_oe     <= 1'b0;
            timeout_err <= 1'b1;
            done        <= 1'b1;
            state       <= ST_IDLE;
          end else begin
            timer <= timer - 20'd1;
          end
        end

        ST_DATA: begin
          clk_oe <= 1'b0;
          if (fall) begin
            data_oe <= ~sh[0];
            sh      <= {1'b1, sh[9:1]};
            timer   <= TIMEOUT_LOAD;
            if (bitcnt == 4'd9) begin
              state <= ST_ACK;
            end else begin
              bitcnt <= bitcnt + 4'd1;
            end
          end else if (timer == '0) begin
            clk_oe      <= 1'b0;
            data_oe     <= 1'b0;
            timeout_err <= 1'b1;
            done        <= 1'b1;
            state       <= ST_IDLE;
          end else begin
            timer <= timer - 20'd1;
          end
        end

        ST_ACK: begin
          clk_oe  <= 1'b0;
          data_oe <= 1'b0;
          if (fall) begin
            ack_err <= data_sync;
            state   <= ST_WAIT_IDLE;
          end else if (timer == '0) begin
            timeout_err <= 1'b1;
            done        <= 1'b1;
            state       <= ST_IDLE;
          end else begin
            timer <= timer - 20'd1;
          end
        end

        ST_WAIT_IDLE: begin
          clk_oe  <= 1'b0;
          data_oe <= 1'b0;
          if (clk_sync && data_sync) begin
            done  <= 1'b1;
            state <= ST_IDLE;
          end
        end

        default: begin
          clk_oe  <= 1'b0;
          data_oe <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: drives ps2_host_tx against a behavioural PS/2 device that
// clocks at about 12.5 kHz, samples data while the clock is low before each
// rising edge, and drives the ack on clock 11.
module tb_ps2_host_tx;

  localparam int HALF = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       ps2_clk_in, ps2_data_in;
  logic       clk_oe, data_oe, busy, rx_inhibit, done, ack_err, timeout_err;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int done_count = 0;
  int done_cyc = 0;
  int rel_cyc = 0;
  int clk_oe_cnt = 0;
  int overlap_cnt = 0;
  int inh_bad = 0;
  logic last_ack = 1'b0;
  logic last_to = 1'b0;
  logic busy_at_done = 1'b0;

  // Open-drain wired-AND of host and device on both lines.
  assign ps2_clk_in  = ~(clk_oe | dev_clk_low);
  assign ps2_data_in = ~(data_oe | dev_data_low);

  ps2_host_tx #(
    .CLK_FREQ  (1_000_000),
    .INHIBIT_US(100),
    .TIMEOUT_US(15000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .clk_oe     (clk_oe),
    .data_oe    (data_oe),
    .busy       (busy),
    .rx_inhibit (rx_inhibit),
    .done       (done),
    .ack_err    (ack_err),
    .timeout_err(timeout_err)
  );

  // 1 MHz system clock, one cycle per 10 time units.
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests_run++;
    assert (obs === expv) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    tests_run++;
    assert (obs >= lo && obs <= hi) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // One system cycle; sample 1 time unit after the rising edge and log events.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (clk_oe) clk_oe_cnt++;
    if (clk_oe && data_oe) overlap_cnt++;
    if (rx_inhibit !== busy) inh_bad++;
    if (done) begin
      done_count++;
      last_ack     = ack_err;
      last_to      = timeout_err;
      busy_at_done = busy;
      done_cyc     = cyc;
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] b);
    tx_data  = b;
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
  endtask

  // Device model. mode: 0 normal, 1 never clocks, 2 no ack,
  // 3 extra tx_start during bit 4, 4 reset during bit 5.
  task automatic run_device(input int mode, output logic [9:0] got, output int wait_cyc);
    int n;
    got = '1;
    wait_cyc = 0;
    n = 0;
    while (!clk_oe && n < 1000) begin tick(); n++; end
    n = 0;
    while (clk_oe && n < 1000) begin tick(); n++; end
    rel_cyc = cyc;
    check_range("inhibit_len", clk_oe_cnt, 100, 102);
    check_output("clk_data_overlap", overlap_cnt, 1);
    repeat (10) tick();
    check_output("start_bit", ps2_data_in, 0);
    if (mode == 1) begin
      n = 0;
      while (done_count == 0 && n < 20000) begin tick(); n++; end
      wait_cyc = done_cyc - rel_cyc;
      return;
    end
    for (int i = 1; i <= 11; i++) begin
      if (i == 11 && mode != 2) dev_data_low = 1'b1;
      repeat (5) tick();
      dev_clk_low = 1'b1;
      for (int k = 0; k < HALF; k++) begin
        tick();
        if (mode == 3 && i == 5 && k == 10) begin
          tx_data  = 8'h5A;
          tx_start = 1'b1;
          tick();
          tx_start = 1'b0;
        end
        if (mode == 4 && i == 6 && k == 10) begin
          #2 rst = 1'b0;
          #1;
          check_output("async_reset_lines", {clk_oe, data_oe, busy}, 3'b000);
          dev_clk_low  = 1'b0;
          dev_data_low = 1'b0;
          return;
        end
      end
      if (i <= 10) got[i-1] = ps2_data_in;
      dev_clk_low = 1'b0;
      repeat (5) tick();
      if (i == 11) dev_data_low = 1'b0;
      repeat (HALF - 10) tick();
    end
    n = 0;
    while (done_count == 0 && n < 200) begin tick(); n++; end
  endtask

  task automatic do_frame(input string tag, input logic [7:0] b, input int mode);
    logic [9:0] got;
    int wait_cyc;
    logic exp_par;
    exp_par = (($countones(b) % 2) == 0);
    clk_oe_cnt  = 0;
    overlap_cnt = 0;
    done_count  = 0;
    inh_bad     = 0;
    apply_stimulus(b);
    check_output({tag, "_busy"}, {busy, rx_inhibit}, 2'b11);
    check_output({tag, "_flags_cleared"}, {ack_err, timeout_err}, 2'b00);
    run_device(mode, got, wait_cyc);
    if (mode == 0 || mode == 3) begin
      check_output({tag, "_byte"}, got[7:0], b);
      check_output({tag, "_parity"}, got[8], exp_par);
      check_output({tag, "_stop"}, got[9], 1);
      check_output({tag, "_done_count"}, done_count, 1);
      check_output({tag, "_errs"}, {last_ack, last_to}, 2'b00);
      check_output({tag, "_busy_at_done"}, busy_at_done, 1);
      check_output({tag, "_busy_after"}, busy, 0);
    end else if (mode == 1) begin
      check_output({tag, "_done_count"}, done_count, 1);
      check_output({tag, "_errs"}, {last_ack, last_to}, 2'b01);
      check_range({tag, "_timeout_cycles"}, wait_cyc, 14990, 15010);
      check_output({tag, "_lines"}, {clk_oe, data_oe}, 2'b00);
    end else if (mode == 2) begin
      check_output({tag, "_byte"}, got[7:0], b);
      check_output({tag, "_done_count"}, done_count, 1);
      check_output({tag, "_errs"}, {last_ack, last_to}, 2'b10);
    end
    check_output({tag, "_rx_inhibit"}, inh_bad, 0);
  endtask

  // Directed sequence with a few randomized bytes between the spec scenarios.
  initial begin
    logic [7:0] rb;
    repeat (3) tick();
    check_output("reset_state", {clk_oe, data_oe, busy, rx_inhibit, done, ack_err, timeout_err}, 7'd0);
    rst = 1'b1;
    repeat (5) tick();

    do_frame("tx_ED", 8'hED, 0);
    do_frame("tx_07", 8'h07, 0);
    do_frame("tx_00", 8'h00, 0);
    for (int r = 0; r < 4; r++) begin
      rb = 8'($urandom_range(0, 255));
      do_frame("tx_rand", rb, 0);
    end

    do_frame("timeout", 8'hF4, 1);
    repeat (20) tick();
    check_output("timeout_flag_hold", timeout_err, 1);

    do_frame("no_ack", 8'hA5, 2);
    repeat (20) tick();
    check_output("ack_flag_hold", ack_err, 1);

    do_frame("start_while_busy", 8'h3C, 3);
    repeat (100) tick();
    check_output("no_queued_frame", {clk_oe, busy}, 2'b00);
    rb = 8'($urandom_range(0, 255));
    do_frame("after_busy", rb, 0);

    do_frame("reset_mid", 8'h33, 4);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    check_output("after_reset", {clk_oe, data_oe, busy, done, ack_err, timeout_err}, 6'd0);
    repeat (5) tick();
    do_frame("tx_FF", 8'hFF, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
